f1_start_seq: RTL
=================

# f1_start_seq

Parametrised F1 start-light sequencer with integrated tick generator and randomised lights-out delay. It succeeds the fixed 8-light clktick + FSM pairing.
- A trigger starts a fill sequence that lights one more lamp per tick.
- After all lamps are lit it holds for a pseudo-random number of ticks, then blanks them and pulses `go`.
- `go` is the start reference for the downstream reaction-time counter. The block sits between the button/debounce logic and the light driver and counter.

## Interface
- `WIDTH`, 16: width of tick period input `N`.
- `LIGHTS`, 8: number of lamps; must be ≥2.
- `DLY_W`, 3: number of LFSR bits used for the hold delay. Hold length is 1..2^DLY_W ticks. DLY_W ≤ 7.

- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  tick-generator enable.
- `N`  in  WIDTH  tick period minus one; sampled on every reload.
- `trigger`  in  1  start request; level-sampled, acted on only in IDLE.
- `abort`  in  1  synchronous cancel; overrides everything except `rst`.
- `data_out`  out  LIGHTS  lamp pattern; bit 0 is the first lamp.
- `tick`  out  1  one-cycle tick strobe (registered).
- `busy`  out  1  high in FILL or HOLD.
- `go`  out  1  one-cycle pulse on the lights-out edge.

## Operation
- Tick generator: down-counter `cnt`.
  - On `rst`: `cnt`=`N`, `tick`=0.
  - When `en`=1 and `cnt`==0: `tick`=1 next cycle and `cnt` reloads `N`.
  - When `en`=1 and `cnt`≠0: `cnt` decrements and `tick`=0.
  - When `en`=0: `cnt` holds and `tick`=0.
- LFSR: 7-bit Fibonacci, polynomial x^7+x^6+1, next = {lfsr[5:0], lfsr[6]^lfsr[5]}. Reset seed 7'h01. It advances every clock cycle regardless of `en`. It never reaches 0.
- FSM states are IDLE, FILL and HOLD.
  - IDLE: `data_out`=0. If `trigger`=1, go to FILL. `data_out` stays 0 on that edge.
  - FILL: on each cycle with `tick`=1, `data_out` <= {`data_out`[LIGHTS-2:0], 1'b1}.
    - On the tick where the new pattern is all ones, go to HOLD on the same edge.
    - On that edge, `dly` <= `lfsr`[DLY_W-1:0], using the LFSR value before the update.
  - HOLD: `data_out` stays all ones.
    - On a tick with `dly`≠0: `dly` decrements.
    - On a tick with `dly`==0: `data_out` <= 0, `go` <= 1 for one cycle, go to IDLE.
- `trigger` in FILL or HOLD is ignored. A held `trigger` on return to IDLE restarts the sequence on the following edge.
- `abort`=1 in any state: on the next edge, state IDLE, `data_out`=0, `dly`=0 and no `go`. The tick generator and LFSR are unaffected.
- `abort` and `tick` in the same cycle: `abort` wins.
- `abort` and `trigger` in IDLE in the same cycle: stay in IDLE.

## Timing
- Reset values:
  - `data_out`=0, `tick`=0, `busy`=0, `go`=0.
  - State IDLE, `cnt`=`N`, `lfsr`=7'h01, `dly`=0.
- Reset mid-sequence (FILL or HOLD) returns all of the above on the next edge. No `go` is emitted.
- Tick period is `N`+1 enabled cycles. `N`=0 gives `tick`=1 every enabled cycle.
- A change to `N` takes effect at the next reload.
- IDLE to FILL takes 1 cycle. The first lamp lights on the first `tick` after entering FILL.
- Sequence length, in ticks after entering FILL:
  - LIGHTS ticks to reach all-on.
  - Then `dly`+1 ticks to lights-out.
- `go` is asserted on the same edge that `data_out` becomes 0. `busy` drops on that same edge.
- All outputs are registered; there is no combinational input-to-output path.

## Test plan
- Tick generator:
  - `rst`, `en`=1, `N`=0: `tick`=1 on every cycle after the first.
  - `N`=3: `tick` is high 1 cycle in 4.
  - `en`=0 for 5 cycles mid-count: `tick`=0 and the period is stretched by 5.
- Full sequence, LIGHTS=8, `N`=0, `trigger` pulsed 1 cycle:
  - `data_out` steps 01, 03, 07, 0F, 1F, 3F, 7F, FF on consecutive ticks.
  - It holds FF for (captured `lfsr`[2:0])+1 ticks, computed by the bench model from seed 01, then 00 with a single `go` pulse.
  - `busy` is high throughout.
- Busy lockout: `trigger` held high through a whole sequence.
  - No restart occurs until IDLE.
  - Then FILL starts one edge after IDLE and `data_out` steps to 01 on the next tick.
- Abort at `data_out`=0F: next edge `data_out`=00, `busy`=0, `go` never asserted. A later `trigger` restarts from 01.
- Reset in HOLD: `rst`=1 for 1 cycle while `data_out`=FF. Next edge all outputs are 0 and `lfsr` restarts from 01 (checked by repeating the full-sequence scenario).
- Parameter sweep at LIGHTS=4, DLY_W=1: pattern 1, 3, 7, F, then hold for 1 or 2 ticks, then 0 with `go`.

Source files
------------

// File: rtl/f1_start_seq.sv
// F1 start-light sequencer: tick generator, free-running LFSR and a
// fill / hold / lights-out state machine. The lamps fill one per tick. After
// a pseudo-random hold they blank, and `go` pulses on that same edge.
module f1_start_seq #(
    parameter int WIDTH  = 16,
    parameter int LIGHTS = 8,
    parameter int DLY_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [WIDTH-1:0]  N,
    input  logic              trigger,
    input  logic              abort,
    output logic [LIGHTS-1:0] data_out,
    output logic              tick,
    output logic              busy,
    output logic              go
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  cnt_q;
    logic              tick_q;
    logic [6:0]        lfsr_q;
    logic [6:0]        lfsr_d;
    logic [DLY_W-1:0]  dly_q;
    logic [LIGHTS-1:0] data_q;
    logic              busy_q;
    logic              go_q;
    logic              fill_last_s;

    // x^7+x^6+1 Fibonacci step; this polynomial never leaves the non-zero orbit
    assign lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};

    // The tick that shifts in the final one is the tick that completes the fill
    assign fill_last_s = &data_q[LIGHTS-2:0];

    // Tick generator: reload from N when the counter expires, strobe tick for one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= N;
            tick_q <= 1'b0;
        end else if (en) begin
            if (cnt_q == {WIDTH{1'b0}}) begin
                tick_q <= 1'b1;
                cnt_q  <= N;
            end else begin
                tick_q <= 1'b0;
                cnt_q  <= cnt_q - WIDTH'(1);
            end
        end else begin
            tick_q <= 1'b0;
        end
    end

    // Free-running LFSR, independent of en, so the hold delay depends on when
    // the fill completes
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 7'h01;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Sequencer FSM with registered lamp, busy and go outputs; abort beats any tick
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            data_q  <= {LIGHTS{1'b0}};
            dly_q   <= {DLY_W{1'b0}};
            busy_q  <= 1'b0;
            go_q    <= 1'b0;
        end else if (abort) begin
            state_q <= S_IDLE;
            data_q  <= {LIGHTS{1'b0}};
            dly_q   <= {DLY_W{1'b0}};
            busy_q  <= 1'b0;
            go_q    <= 1'b0;
        end else begin
            go_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    data_q <= {LIGHTS{1'b0}};
                    if (trigger) begin
                        state_q <= S_FILL;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (tick_q) begin
                        data_q <= {data_q[LIGHTS-2:0], 1'b1};
                        if (fill_last_s) begin
                            state_q <= S_HOLD;
                            dly_q   <= lfsr_q[DLY_W-1:0];
                        end else begin
                            state_q <= S_FILL;
                        end
                    end else begin
                        state_q <= S_FILL;
                    end
                end
                S_HOLD: begin
                    if (tick_q) begin
                        if (dly_q != {DLY_W{1'b0}}) begin
                            dly_q <= dly_q - DLY_W'(1);
                        end else begin
                            data_q  <= {LIGHTS{1'b0}};
                            go_q    <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end else begin
                        state_q <= S_HOLD;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    data_q  <= {LIGHTS{1'b0}};
                    dly_q   <= {DLY_W{1'b0}};
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out = data_q;
    assign tick     = tick_q;
    assign busy     = busy_q;
    assign go       = go_q;

endmodule
